seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/mdu_iter.sv | 95 +++++++++
 rtl/seq_alu.sv | 179 +++++++++++++++++
 tb/tb_seq_alu.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: ctrl codes, FSM states and op classification.
// Multiply/divide support is gated by the ALU_MDU_EN macro in the files that use it.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_AND    = 5'h02,
    OP_OR     = 5'h03,
    OP_XOR    = 5'h04,
    OP_SLL    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_SLT    = 5'h08,
    OP_SLTU   = 5'h09,
    OP_PASS   = 5'h0A,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_SINGLE = 2'd0,
    CLS_MUL    = 2'd1,
    CLS_DIV    = 2'd2
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] code);
    op_class_e cls;
    cls = CLS_SINGLE;
    if (code[4:3] == 2'b10)
      cls = code[2] ? CLS_DIV : CLS_MUL;
    return cls;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring divider on magnitudes,
// one bit per cycle for DATA_WIDTH cycles, sign applied on the outputs.
module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          running;
  logic [CW-1:0] cnt;
  logic          is_div, neg_res, neg_rem;
  logic [2*W-1:0] acc, mcand, prod;
  logic [W-1:0]  mplier, quo, rem, dvsr;
  logic          a_sgn, b_sgn, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    rem_sh, diff;

  // op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
  always_comb begin
    a_sgn  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg  = a_sgn & a[W-1];
    b_neg  = b_sgn & b[W-1];
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    rem_sh = {rem, quo[W-1]};
    diff   = rem_sh - {1'b0, dvsr};
    prod   = neg_res ? -acc : acc;
    hi     = is_div ? (neg_rem ? -rem : rem) : prod[2*W-1:W];
    lo     = is_div ? (neg_res ? -quo : quo) : prod[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
    end else if (start) begin
      running <= 1'b1;
      done    <= 1'b0;
      cnt     <= '0;
      is_div  <= op[2];
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      acc     <= '0;
      mcand   <= {{W{1'b0}}, a_mag};
      mplier  <= b_mag;
      rem     <= '0;
      quo     <= a_mag;
      dvsr    <= b_mag;
    end else if (running) begin
      if (is_div) begin
        if (!diff[W]) begin
          rem <= diff[W-1:0];
          quo <= {quo[W-2:0], 1'b1};
        end else begin
          rem <= rem_sh[W-1:0];
          quo <= {quo[W-2:0], 1'b0};
        end
      end else begin
        if (mplier[0])
          acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        running <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready request and response handshakes.
// Define ALU_MDU_EN to enable the iterative multiply/divide codes (10-17); otherwise they return 0.
module seq_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [4:0]            ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  eq,
  output logic                  less,
  output logic                  lessu,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;

  state_e        state, state_n;
  logic          accept;
  logic          lt_s, lt_u;
  logic [W-1:0]  single_res;
  logic [SHAMT_W-1:0] shamt;

`ifdef ALU_MDU_EN
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};

  op_class_e     cls;
  logic          div0, ovf, iter_go, fin, sel_hi, mdu_done;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [W-1:0]  mdu_hi, mdu_lo;
`endif

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_valid = (state == DONE);
  assign shamt     = op2[SHAMT_W-1:0];
  assign lt_s      = $signed(op1) < $signed(op2);
  assign lt_u      = op1 < op2;

  always_comb begin
    single_res = '0;
    case (ctrl)
      OP_ADD:  single_res = op1 + op2;
      OP_SUB:  single_res = op1 - op2;
      OP_AND:  single_res = op1 & op2;
      OP_OR:   single_res = op1 | op2;
      OP_XOR:  single_res = op1 ^ op2;
      OP_SLL:  single_res = op1 << shamt;
      OP_SRL:  single_res = op1 >> shamt;
      OP_SRA:  single_res = $signed(op1) >>> shamt;
      OP_SLT:  single_res = {{(W-1){1'b0}}, lt_s};
      OP_SLTU: single_res = {{(W-1){1'b0}}, lt_u};
      OP_PASS: single_res = op2;
      default: single_res = '0;
    endcase
`ifdef ALU_MDU_EN
    // Divide by zero and signed overflow resolve here and never enter the divider.
    cls  = op_class(ctrl);
    div0 = (op2 == '0);
    ovf  = !ctrl[0] && (op1 == SMIN) && (op2 == '1);
    if (cls == CLS_DIV) begin
      if (div0)
        single_res = ctrl[1] ? op1 : '1;
      else if (ovf)
        single_res = ctrl[1] ? '0 : op1;
    end
    iter_go = (cls == CLS_MUL) || ((cls == CLS_DIV) && !div0 && !ovf);
`endif
  end

`ifdef ALU_MDU_EN
  assign fin    = mdu_done && (cnt == CNT_LAST);
  assign sel_hi = op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00);
  assign busy   = (state == MUL) || (state == DIV);

  mdu_iter #(
    .DATA_WIDTH(W)
  ) u_mdu (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept && iter_go),
    .op   (ctrl[2:0]),
    .a    (op1),
    .b    (op2),
    .done (mdu_done),
    .hi   (mdu_hi),
    .lo   (mdu_lo)
  );
`else
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_MDU_EN
          state_n = iter_go ? ((cls == CLS_MUL) ? MUL : DIV) : DONE;
`else
          state_n = DONE;
`endif
        end
      end
      MUL, DIV: begin
`ifdef ALU_MDU_EN
        if (fin) state_n = DONE;
`else
        state_n = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
`ifdef ALU_MDU_EN
            state_n = iter_go ? ((cls == CLS_MUL) ? MUL : DIV) : DONE;
`else
            state_n = DONE;
`endif
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      eq     <= 1'b0;
      less   <= 1'b0;
      lessu  <= 1'b0;
`ifdef ALU_MDU_EN
      cnt    <= '0;
      op_q   <= '0;
`endif
    end else begin
      if (accept) begin
        eq    <= (op1 == op2);
        less  <= lt_s;
        lessu <= lt_u;
`ifdef ALU_MDU_EN
        op_q  <= ctrl[2:0];
        cnt   <= '0;
        if (!iter_go) result <= single_res;
`else
        result <= single_res;
`endif
      end
`ifdef ALU_MDU_EN
      else if (busy) begin
        // Counter parks at its last value until the unit's final step has landed.
        if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        if (fin) result <= sel_hi ? mdu_hi : mdu_lo;
      end
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, multi-cycle corner sequences,
// and randomized operations against a plain-arithmetic reference model.
module tb_seq_alu;

  localparam int W = 32;
`ifdef ALU_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif
  localparam int ITER_LAT = MDU ? (W + 1) : 1;

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  op1, op2, result;
  logic [4:0]    ctrl;
  logic          eq, less, lessu, busy;

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op1      (op1),
    .op2      (op2),
    .ctrl     (ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .eq       (eq),
    .less     (less),
    .lessu    (lessu),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: straight arithmetic on 64-bit integers.
  function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (c)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return a & b;
      5'h03: return a | b;
      5'h04: return a ^ b;
      5'h05: return a << b[4:0];
      5'h06: return a >> b[4:0];
      5'h07: return 32'(sa >>> b[4:0]);
      5'h08: return (sa < sb) ? 32'd1 : 32'd0;
      5'h09: return (ua < ub) ? 32'd1 : 32'd0;
      5'h0A: return b;
      default: ;
    endcase
    if (MDU) begin
      case (c)
        5'h10: begin p = 64'(ua * ub); return p[31:0]; end
        5'h11: begin p = 64'(sa * sb); return p[63:32]; end
        5'h12: begin p = 64'(sa * ub); return p[63:32]; end
        5'h13: begin p = 64'(ua * ub); return p[63:32]; end
        5'h14: if (b == 0) return 32'hFFFF_FFFF;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
               else return 32'(sa / sb);
        5'h15: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
        5'h16: if (b == 0) return a;
               else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
               else return 32'(sa % sb);
        5'h17: return (b == 0) ? a : 32'(ua % ub);
        default: ;
      endcase
    end
    return 32'd0;
  endfunction

  function automatic int ref_lat(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (b == 0) || (c[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (!MDU) return 1;
    if (c >= 5'h10 && c <= 5'h13) return ITER_LAT;
    if (c >= 5'h14 && c <= 5'h17 && !special) return ITER_LAT;
    return 1;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [2:0] fl, output int lat);
    int guard;
    op1 = a; op2 = b; ctrl = c; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) chk("in_ready_wait", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    r  = result;
    fl = {eq, less, lessu};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  logic [4:0] pool [21] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
                            5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h0B, 5'h1F};

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] r, r0, ea, eb;
    logic [2:0]  fl, efl;
    logic [4:0]  ec;
    int          lat;
    bit          seen;

    vecs.push_back('{5'h07, 32'h8000_0010, 32'd4,         32'hF800_0001, 1});
    vecs.push_back('{5'h00, 32'd3,         32'd4,         32'd7,         1});
    vecs.push_back('{5'h01, 32'd3,         32'd4,         32'hFFFF_FFFF, 1});
    vecs.push_back('{5'h02, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1});
    vecs.push_back('{5'h03, 32'hF000_0001, 32'h0000_00F0, 32'hF000_00F1, 1});
    vecs.push_back('{5'h04, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1});
    vecs.push_back('{5'h05, 32'd1,         32'd31,        32'h8000_0000, 1});
    vecs.push_back('{5'h05, 32'h0000_0011, 32'd36,        32'h0000_0110, 1});
    vecs.push_back('{5'h06, 32'h8000_0000, 32'd31,        32'd1,         1});
    vecs.push_back('{5'h08, 32'hFFFF_FFFF, 32'd1,         32'd1,         1});
    vecs.push_back('{5'h09, 32'hFFFF_FFFF, 32'd1,         32'd0,         1});
    vecs.push_back('{5'h0A, 32'd9,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1});
    vecs.push_back('{5'h0B, 32'd9,         32'd5,         32'd0,         1});
    vecs.push_back('{5'h1F, 32'd9,         32'd5,         32'd0,         1});
    vecs.push_back('{5'h14, 32'hFFFF_FFF9, 32'd2,         MDU ? 32'hFFFF_FFFD : 32'd0, ITER_LAT});
    vecs.push_back('{5'h16, 32'hFFFF_FFF9, 32'd2,         MDU ? 32'hFFFF_FFFF : 32'd0, ITER_LAT});
    vecs.push_back('{5'h15, 32'd5,         32'd0,         MDU ? 32'hFFFF_FFFF : 32'd0, 1});
    vecs.push_back('{5'h17, 32'd5,         32'd0,         MDU ? 32'd5 : 32'd0,         1});
    vecs.push_back('{5'h14, 32'h8000_0000, 32'hFFFF_FFFF, MDU ? 32'h8000_0000 : 32'd0, 1});
    vecs.push_back('{5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,                       1});
    vecs.push_back('{5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MDU ? 32'hFFFF_FFFE : 32'd0, ITER_LAT});
    vecs.push_back('{5'h10, 32'd7,         32'd6,         MDU ? 32'd42 : 32'd0,        ITER_LAT});
    vecs.push_back('{5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,                       ITER_LAT});
    vecs.push_back('{5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MDU ? 32'hFFFF_FFFF : 32'd0, ITER_LAT});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op1 = '0; op2 = '0; ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy",      {63'b0, busy},      64'd0);
    chk("rst_result",    {32'b0, result},    64'd0);
    chk("rst_flags",     {61'b0, eq, less, lessu}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, r, fl, lat);
      efl = {vecs[i].a == vecs[i].b, $signed(vecs[i].a) < $signed(vecs[i].b), vecs[i].a < vecs[i].b};
      chk($sformatf("vec%0d_result", i), {32'b0, r}, {32'b0, vecs[i].res});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_flags", i), {61'b0, fl}, {61'b0, efl});
    end

    // MULHU with response back-pressure for five cycles.
    op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF; ctrl = 5'h13; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_busy",     {63'b0, busy},     64'(MDU));
    chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
    wait_valid(lat);
    chk("stall_latency", 64'(lat), 64'(ITER_LAT));
    r0 = MDU ? 32'hFFFF_FFFE : 32'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_result", k), {32'b0, result}, {32'b0, r0});
      chk($sformatf("stall%0d_valid", k), {63'b0, out_valid}, 64'd1);
      chk($sformatf("stall%0d_in_ready", k), {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall_release", {63'b0, out_valid}, 64'd0);

    // Back-to-back: new request accepted in the same cycle the response is taken.
    run_op(5'h00, 32'd1, 32'd2, r, fl, lat);
    op1 = 32'd10; op2 = 32'd20; ctrl = 5'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_first", {32'b0, result}, 64'd30);
    op1 = 32'd5; op2 = 32'd3; ctrl = 5'h04; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_valid",  {63'b0, out_valid}, 64'd1);
    chk("b2b_second", {32'b0, result},    64'd6);
    chk("b2b_flags",  {61'b0, eq, less, lessu}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during a DIV discards it.
    op1 = 32'hFFFF_FFF9; op2 = 32'd2; ctrl = 5'h14; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rdiv_busy", {63'b0, busy}, 64'(MDU));
    #2 rst_n = 1'b0;
    #1;
    chk("rdiv_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rdiv_busy_rst",  {63'b0, busy},      64'd0);
    chk("rdiv_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rdiv_result",    {32'b0, result},    64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rdiv_no_response", {63'b0, seen}, 64'd0);
    run_op(5'h00, 32'd3, 32'd4, r, fl, lat);
    chk("rdiv_add_result", {32'b0, r}, 64'd7);
    chk("rdiv_add_flags",  {61'b0, fl}, {61'b0, 3'b011});

    // Randomized operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      ec = pool[$urandom_range(0, 20)];
      ea = rnd_op();
      eb = rnd_op();
      run_op(ec, ea, eb, r, fl, lat);
      efl = {ea == eb, $signed(ea) < $signed(eb), ea < eb};
      chk($sformatf("rnd%0d_c%0h_result", n, ec), {32'b0, r}, {32'b0, ref_alu(ec, ea, eb)});
      chk($sformatf("rnd%0d_c%0h_latency", n, ec), 64'(lat), 64'(ref_lat(ec, ea, eb)));
      chk($sformatf("rnd%0d_flags", n), {61'b0, fl}, {61'b0, efl});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
